// File: rtl/cnfg_wr_if.sv
// rtl/cnfg_wr_if.sv - serial command input and latch register-file bus of cnfg_wr_decoder
interface cnfg_wr_if;
    logic        ser_in;
    logic        ser_valid;
    logic [3:0]  chip_id;
    logic [4:0]  addr;
    logic [15:0] data_in;
    logic        we;
    logic        rd_req;
    logic        busy;
    logic        err;

    modport master (
        output ser_in, ser_valid, chip_id,
        input  addr, data_in, we, rd_req, busy, err
    );

    modport slave (
        input  ser_in, ser_valid, chip_id,
        output addr, data_in, we, rd_req, busy, err
    );
endinterface

// File: rtl/cnfg_wr_decoder.sv
// rtl/cnfg_wr_decoder.sv - serial config command decoder driving a latch register file
// Frame: header 10110, field(4), chip id(4), address(6), data(16, writes only), MSB first.
module cnfg_wr_decoder (
    input  logic     clk_i,
    input  logic     rst_i,
    cnfg_wr_if.slave bus_if
);
    localparam logic [4:0] HEADER   = 5'b10110;
    localparam logic [3:0] FIELD_WR = 4'b0010;
    localparam logic [3:0] FIELD_RD = 4'b0001;

    typedef enum logic [3:0] {
        S_HUNT,
        S_FIELD,
        S_CHIPID,
        S_ADDR,
        S_DATA,
        S_SKIP,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_READ
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  window_q, window_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [14:0] shift_q, shift_d;
    logic        is_wr_q, is_wr_d;
    logic        match_q, match_d;
    logic [4:0]  rx_addr_q, rx_addr_d;
    logic [4:0]  addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        err_q, err_d;

    logic        bit_v;
    logic [15:0] shifted;
    logic [4:0]  window_next;

    assign bit_v       = bus_if.ser_valid;
    assign shifted     = {shift_q, bus_if.ser_in};
    assign window_next = {window_q[3:0], bus_if.ser_in};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_HUNT;
            window_q  <= '0;
            cnt_q     <= '0;
            shift_q   <= '0;
            is_wr_q   <= 1'b0;
            match_q   <= 1'b0;
            rx_addr_q <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            window_q  <= window_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            is_wr_q   <= is_wr_d;
            match_q   <= match_d;
            rx_addr_q <= rx_addr_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        window_d  = window_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        is_wr_d   = is_wr_q;
        match_d   = match_q;
        rx_addr_d = rx_addr_q;
        addr_d    = addr_q;
        data_d    = data_q;
        err_d     = 1'b0;

        case (state_q)
            // Window restarts empty so a header can never borrow bits from the previous frame.
            S_HUNT: begin
                if (bit_v) begin
                    window_d = window_next;
                    if (window_next == HEADER) begin
                        window_d = '0;
                        cnt_d    = '0;
                        state_d  = S_FIELD;
                    end
                end
            end
            S_FIELD: begin
                if (bit_v) begin
                    shift_d = shifted[14:0];
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd3) begin
                        cnt_d = '0;
                        if (shifted[3:0] == FIELD_WR || shifted[3:0] == FIELD_RD) begin
                            is_wr_d = (shifted[3:0] == FIELD_WR);
                            state_d = S_CHIPID;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_HUNT;
                        end
                    end
                end
            end
            S_CHIPID: begin
                if (bit_v) begin
                    shift_d = shifted[14:0];
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd3) begin
                        cnt_d   = '0;
                        match_d = (shifted[3:0] == bus_if.chip_id) || shifted[3];
                        state_d = S_ADDR;
                    end
                end
            end
            // A foreign or out-of-range write still owns 16 data bits that must be swallowed.
            S_ADDR: begin
                if (bit_v) begin
                    shift_d = shifted[14:0];
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd5) begin
                        cnt_d = '0;
                        if (!match_q) begin
                            state_d = is_wr_q ? S_SKIP : S_HUNT;
                        end else if (shifted[5]) begin
                            err_d   = 1'b1;
                            state_d = is_wr_q ? S_SKIP : S_HUNT;
                        end else if (is_wr_q) begin
                            rx_addr_d = shifted[4:0];
                            state_d   = S_DATA;
                        end else begin
                            addr_d  = shifted[4:0];
                            state_d = S_READ;
                        end
                    end
                end
            end
            S_DATA: begin
                if (bit_v) begin
                    shift_d = shifted[14:0];
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        cnt_d   = '0;
                        addr_d  = rx_addr_q;
                        data_d  = shifted;
                        state_d = S_SETUP;
                    end
                end
            end
            S_SKIP: begin
                if (bit_v) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        cnt_d   = '0;
                        state_d = S_HUNT;
                    end
                end
            end
            // Bits arriving while the register file is being driven are lost and flagged.
            S_SETUP: begin
                err_d   = bit_v;
                state_d = S_STROBE;
            end
            S_STROBE: begin
                err_d   = bit_v;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                err_d   = bit_v;
                state_d = S_HUNT;
            end
            S_READ: begin
                err_d   = bit_v;
                state_d = S_HUNT;
            end
            default: begin
                state_d = S_HUNT;
            end
        endcase
    end

    assign bus_if.addr    = addr_q;
    assign bus_if.data_in = data_q;
    assign bus_if.we      = (state_q == S_STROBE);
    assign bus_if.rd_req  = (state_q == S_READ);
    assign bus_if.busy    = (state_q != S_HUNT);
    assign bus_if.err     = err_q;
endmodule

// File: doc/cnfg_wr_decoder.md
CNFG_WR_DECODER -- requirements
Module: cnfg_wr_decoder

Interface
REQ-001 Clk  input  1  single clock; all state updates on rising edge.
REQ-002 Reset  input  1  synchronous, active-high reset.
REQ-003 SerIn  input  1  serial command bit, MSB first.
REQ-004 SerValid  input  1  qualifies SerIn; bit consumed only on cycles with SerValid=1.
REQ-005 ChipId  input  4  this chip's address; sampled when the chip-ID field completes.
REQ-006 Addr  output  5  config register address for the latch register file.
REQ-007 DataIn  output  16  write data for the latch register file.
REQ-008 WE  output  1  write-enable strobe to the latch register file.
REQ-009 RdReq  output  1  one-cycle read-request pulse; Addr is valid while it is high.
REQ-010 Busy  output  1  high in any state other than HUNT.
REQ-011 Err  output  1  one-cycle error pulse.

Function
REQ-012 Command frame, in bit order: header 5'b10110, field 4 bits, chip ID 4 bits, address 6 bits, then 16 data bits for writes only.
REQ-013 Field 4'b0010 = WrRegister; 4'b0001 = RdRegister; any other value -> Err pulse, return to HUNT.
REQ-014 HUNT: shift qualified bits into a 5-bit window; header match moves to FIELD on the next cycle; the bit counter is cleared on entry to each field state.
REQ-015 The chip matches when the received ID equals ChipId or the received ID bit 3 is 1 (broadcast); on mismatch, consume the remaining frame bits without any WE/RdReq/Err, then return to HUNT.
REQ-016 Received address bit 5 = 1 -> out of range: Err pulse after the address field, no WE/RdReq, skip any data bits, return to HUNT.
REQ-017 Write path DATA -> SETUP -> STROBE -> HOLD -> HUNT, one cycle each.
REQ-018 Addr and DataIn are loaded on entry to SETUP and stay stable through HOLD; WE=1 only in STROBE.
REQ-019 Read path: after a valid address, one READ cycle with RdReq=1 and Addr driven, then HUNT; DataIn unchanged.
REQ-020 Addr and DataIn hold their last values outside the write and read paths and never glitch while WE=1.
REQ-021 SerValid=0 stalls every serial field state: no shift, no count.
REQ-022 A SerValid=1 bit arriving in SETUP/STROBE/HOLD/READ is dropped and pulses Err; the sequence still completes.
REQ-023 Frame latency: WE rises 2 cycles after the cycle in which the last data bit is consumed.
REQ-024 Header search in HUNT is bit-sliding: a header may begin at any bit, including immediately after HOLD or READ.
REQ-025 At most one of WE, RdReq, Err is high in any cycle, except for a dropped-bit Err under REQ-022.

Reset
REQ-026 Reset=1 in any state -> next cycle: state HUNT, header window and counters 0, Addr=0, DataIn=0, WE=0, RdReq=0, Busy=0, Err=0.
REQ-027 Reset asserted during STROBE deasserts WE on the next edge; no partial frame is completed after reset.
REQ-028 Reset has priority over SerValid in the same cycle.

Verification
REQ-029 ChipId=4'h3; stream 10110 0010 0011 000101 0xA5C3 -> Addr=5 and DataIn=0xA5C3 in SETUP; WE high exactly 1 cycle, 2 cycles after the last bit; Busy low after HOLD.
REQ-030 ChipId=4'h3; stream 10110 0001 1000 011111 -> RdReq 1 cycle with Addr=31; no WE; DataIn unchanged.
REQ-031 ChipId=4'h3; stream with ID 0101 followed by a valid write -> first frame produces no WE/Err; second frame writes correctly.
REQ-032 Address 100000 or field 0111 -> one Err pulse, no WE; a valid frame sent immediately afterwards is accepted.
REQ-033 Write frame with SerValid toggling 1/0 every cycle, plus one extra valid bit during STROBE -> correct write and one Err; Reset pulsed mid-DATA -> all outputs 0, no WE.
